// File: rtl/dport_scrambler_pkg.sv
// Shared DisplayPort scrambler constants and the single-bit Galois LFSR step.
package dport_scrambler_pkg;

    localparam logic [7:0]  K28_5    = 8'hBC;
    localparam logic [7:0]  K28_0    = 8'h1C;
    localparam logic [15:0] SCR_SEED = 16'hFFFF;
    localparam logic [15:0] SCR_POLY = 16'h0039;

    // G(X) = X^16+X^5+X^4+X^3+1 in Galois form; the bit shifted out is the key bit.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? SCR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/dport_scrambler_scrbyte.sv
// One symbol slot of the scrambler: key byte generation, data XOR, and the
// SR-triggered reload of the LFSR.
module dport_scrbyte
    import dport_scrambler_pkg::*;
#(
    parameter logic [15:0] SEED = SCR_SEED
) (
    input  logic [7:0]  sym,
    input  logic        isk,
    input  logic        scren,
    input  logic [15:0] lfsr,
    output logic [7:0]  sym_scr,
    output logic [7:0]  key,
    output logic [15:0] lfsr_next
);

    logic [15:0] state;

    always_comb begin
        state = lfsr;
        key   = '0;
        for (int i = 0; i < 8; i++) begin
            key[i] = state[15];
            state  = lfsr_step(state);
        end
        sym_scr   = (scren && !isk) ? (sym ^ key) : sym;
        // An SR restarts the keystream for the very next symbol.
        lfsr_next = (isk && (sym == K28_0)) ? SEED : state;
    end

endmodule

// File: rtl/dport_scrambler.sv
// Two-lane DisplayPort main-link scrambler with one cycle of latency.
// DPORT_SCR_SR_EN enables periodic BS->SR substitution; without it the framer must supply SR.
module dport_scrambler
    import dport_scrambler_pkg::*;
#(
    parameter logic [15:0] SEED = SCR_SEED
`ifdef DPORT_SCR_SR_EN
    ,
    parameter int SR_PERIOD = 512
`endif
) (
    input  logic        dpclk,
    input  logic        rst_n,
    input  logic        scren,
    input  logic [15:0] indat0,
    input  logic [15:0] indat1,
    input  logic [1:0]  inisk0,
    input  logic [1:0]  inisk1,
    output logic [15:0] scrdat0,
    output logic [15:0] scrdat1,
    output logic [1:0]  scrisk0,
    output logic [1:0]  scrisk1
);

    logic [15:0] lfsr;
    logic [15:0] lfsr_mid;
    logic [15:0] lfsr_nxt;
    logic [7:0]  sym0_a, sym0_b, sym1_a, sym1_b;
    logic        k1_a, k1_b;
    logic [7:0]  scr_a, scr_b, key_a, key_b;
    logic [7:0]  lane1_a, lane1_b;

`ifdef DPORT_SCR_SR_EN
    localparam int CW = (SR_PERIOD > 1) ? $clog2(SR_PERIOD) : 1;

    logic [CW-1:0] bscnt;
    logic [CW-1:0] bscnt_mid;
    logic [CW-1:0] bscnt_nxt;
    logic          bs_a, bs_b, sub_a, sub_b;

    // Byte 1 sees the BS count already advanced by a BS in byte 0.
    always_comb begin
        bs_a      = inisk0[0] && (indat0[7:0] == K28_5);
        sub_a     = bs_a && (bscnt == '0);
        bscnt_mid = bs_a ? bscnt + 1'b1 : bscnt;
        bs_b      = inisk0[1] && (indat0[15:8] == K28_5);
        sub_b     = bs_b && (bscnt_mid == '0);
        bscnt_nxt = bs_b ? bscnt_mid + 1'b1 : bscnt_mid;
        sym0_a    = sub_a ? K28_0 : indat0[7:0];
        sym1_a    = sub_a ? K28_0 : indat1[7:0];
        k1_a      = sub_a | inisk1[0];
        sym0_b    = sub_b ? K28_0 : indat0[15:8];
        sym1_b    = sub_b ? K28_0 : indat1[15:8];
        k1_b      = sub_b | inisk1[1];
    end

    always_ff @(posedge dpclk or negedge rst_n) begin
        if (!rst_n) begin
            bscnt <= '0;
        end else begin
            bscnt <= bscnt_nxt;
        end
    end
`else
    assign sym0_a = indat0[7:0];
    assign sym1_a = indat1[7:0];
    assign k1_a   = inisk1[0];
    assign sym0_b = indat0[15:8];
    assign sym1_b = indat1[15:8];
    assign k1_b   = inisk1[1];
`endif

    dport_scrbyte #(.SEED(SEED)) u_byte0 (
        .sym       (sym0_a),
        .isk       (inisk0[0]),
        .scren     (scren),
        .lfsr      (lfsr),
        .sym_scr   (scr_a),
        .key       (key_a),
        .lfsr_next (lfsr_mid)
    );

    dport_scrbyte #(.SEED(SEED)) u_byte1 (
        .sym       (sym0_b),
        .isk       (inisk0[1]),
        .scren     (scren),
        .lfsr      (lfsr_mid),
        .sym_scr   (scr_b),
        .key       (key_b),
        .lfsr_next (lfsr_nxt)
    );

    // Lane 1 reuses lane 0's keystream; its own K symbols never touch the LFSR.
    assign lane1_a = (scren && !k1_a) ? (sym1_a ^ key_a) : sym1_a;
    assign lane1_b = (scren && !k1_b) ? (sym1_b ^ key_b) : sym1_b;

    always_ff @(posedge dpclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= SEED;
            scrdat0 <= '0;
            scrdat1 <= '0;
            scrisk0 <= '0;
            scrisk1 <= '0;
        end else begin
            lfsr    <= lfsr_nxt;
            scrdat0 <= {scr_b, scr_a};
            scrdat1 <= {lane1_b, lane1_a};
            scrisk0 <= inisk0;
            scrisk1 <= {k1_b, k1_a};
        end
    end

endmodule

// File: tb/tb_dport_scrambler.sv
// Self-checking bench for dport_scrambler: directed scenarios plus random traffic
// against a keystream-table reference model. Honours DPORT_SCR_SR_EN.
module tb_dport_scrambler;

    logic        dpclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scren = 1'b0;
    logic [15:0] indat0 = '0;
    logic [15:0] indat1 = '0;
    logic [1:0]  inisk0 = '0;
    logic [1:0]  inisk1 = '0;
    logic [15:0] scrdat0, scrdat1;
    logic [1:0]  scrisk0, scrisk1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: keystream bits from SEED, indexed by bit position since the last SR.
    bit          ks_bits[65535];
    int          m_pos;
    int          m_bscnt;
    logic [15:0] e_dat0, e_dat1;
    logic [1:0]  e_isk0, e_isk1;

    dport_scrambler dut (
        .dpclk   (dpclk),
        .rst_n   (rst_n),
        .scren   (scren),
        .indat0  (indat0),
        .indat1  (indat1),
        .inisk0  (inisk0),
        .inisk1  (inisk1),
        .scrdat0 (scrdat0),
        .scrdat1 (scrdat1),
        .scrisk0 (scrisk0),
        .scrisk1 (scrisk1)
    );

    always #5 dpclk = ~dpclk;

    task automatic build_keystream();
        logic [15:0] s;
        s = 16'hFFFF;
        for (int j = 0; j < 65535; j++) begin
            ks_bits[j] = s[15];
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
        end
    endtask

    task automatic model_reset();
        m_pos   = 0;
        m_bscnt = 0;
    endtask

    task automatic model_cycle();
        for (int s = 0; s < 2; s++) begin
            logic [7:0] b0, b1, ks;
            logic       k0, k1;
            b0 = indat0[8*s +: 8];
            b1 = indat1[8*s +: 8];
            k0 = inisk0[s];
            k1 = inisk1[s];
`ifdef DPORT_SCR_SR_EN
            if (k0 && b0 == 8'hBC) begin
                if (m_bscnt == 0) begin
                    b0 = 8'h1C;
                    b1 = 8'h1C;
                    k1 = 1'b1;
                end
                m_bscnt = (m_bscnt + 1) % 512;
            end
`endif
            for (int i = 0; i < 8; i++) ks[i] = ks_bits[(m_pos + i) % 65535];
            m_pos = (m_pos + 8) % 65535;
            e_dat0[8*s +: 8] = (scren && !k0) ? (b0 ^ ks) : b0;
            e_dat1[8*s +: 8] = (scren && !k1) ? (b1 ^ ks) : b1;
            e_isk0[s] = k0;
            e_isk1[s] = k1;
            if (k0 && b0 == 8'h1C) m_pos = 0;
        end
    endtask

    task automatic step(input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] k0, input logic [1:0] k1, input logic en);
        indat0 = d0;
        indat1 = d1;
        inisk0 = k0;
        inisk1 = k1;
        scren  = en;
        model_cycle();
        @(posedge dpclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge dpclk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge dpclk);
        @(posedge dpclk);
        #1;
        n_tests++;
        if ({scrdat0, scrdat1, scrisk0, scrisk1} !== 36'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h %h %b %b, want all zero", scrdat0, scrdat1, scrisk0, scrisk1);
        end
        rst_n = 1'b1;
        model_reset();
        step(16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
        n_tests++;
        if (scrdat0 !== 16'h17FF || scrdat1 !== 16'h17FF || scrisk0 !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_seed: got %h %h isk %b, want 17ff 17ff isk 00", scrdat0, scrdat1, scrisk0);
        end
    endtask

    task automatic test_keystream();
        logic [7:0] k;
`ifdef DPORT_SCR_SR_EN
        k = 8'hBC;
`else
        k = 8'h1C;
`endif
        do_reset();
        step({8'h00, k}, {8'h00, k}, 2'b01, 2'b01, 1'b1);
        n_tests++;
        if (scrdat0 !== 16'hFF1C || scrdat1 !== 16'hFF1C || scrisk0 !== 2'b01 || scrisk1 !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL keystream_c0: got %h %h isk %b %b, want ff1c ff1c isk 01 01", scrdat0, scrdat1, scrisk0, scrisk1);
        end
        step(16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
        n_tests++;
        if (scrdat0 !== 16'hC017 || scrdat1 !== 16'hC017 || scrisk0 !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL keystream_c1: got %h %h isk %b, want c017 c017 isk 00", scrdat0, scrdat1, scrisk0);
        end
        step(16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
        n_tests++;
        if (scrdat0[7:0] !== 8'h14 || scrdat0 !== e_dat0 || scrdat1 !== e_dat1) begin
            n_fail++;
            $display("[TB] FAIL keystream_c2: got %h %h, want low byte 14, model %h %h", scrdat0, scrdat1, e_dat0, e_dat1);
        end
    endtask

    task automatic test_scren_off();
        do_reset();
        step(16'h1234, 16'h5678, 2'b00, 2'b00, 1'b0);
        n_tests++;
        if (scrdat0 !== 16'h1234 || scrdat1 !== 16'h5678) begin
            n_fail++;
            $display("[TB] FAIL scren_off: got %h %h, want 1234 5678", scrdat0, scrdat1);
        end
        step(16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
        n_tests++;
        if (scrdat0 !== 16'h14C0 || scrdat1 !== 16'h14C0) begin
            n_fail++;
            $display("[TB] FAIL scren_resume: got %h %h, want 14c0 14c0", scrdat0, scrdat1);
        end
    endtask

    task automatic test_sr_in_byte0();
        step(16'($urandom), 16'($urandom), 2'b00, 2'b00, 1'b1);
        step({8'h00, 8'h1C}, {8'hA5, 8'h1C}, 2'b01, 2'b01, 1'b1);
        n_tests++;
        if (scrdat0 !== 16'hFF1C || scrdat1 !== 16'h5A1C || scrisk0 !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL sr_byte0: got %h %h isk %b, want ff1c 5a1c isk 01", scrdat0, scrdat1, scrisk0);
        end
    endtask

    task automatic test_lane1_k();
        step(16'($urandom), 16'($urandom), 2'b00, 2'b00, 1'b1);
        step(16'($urandom), {8'h1C, 8'hBC}, 2'b00, 2'b11, 1'b1);
        n_tests++;
        if (scrdat1 !== 16'h1CBC || scrisk1 !== 2'b11 || scrdat0 !== e_dat0) begin
            n_fail++;
            $display("[TB] FAIL lane1_k: got %h %h isk1 %b, want %h 1cbc isk1 11", scrdat0, scrdat1, scrisk1, e_dat0);
        end
        step(16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
        n_tests++;
        if (scrdat0 !== e_dat0 || scrdat1 !== e_dat1) begin
            n_fail++;
            $display("[TB] FAIL lane1_no_lfsr_reset: got %h %h, want %h %h", scrdat0, scrdat1, e_dat0, e_dat1);
        end
    endtask

    task automatic test_bs_period();
        int n_cyc;
        int errs;
        int subs[$];
`ifdef DPORT_SCR_SR_EN
        n_cyc = 1024;
`else
        n_cyc = 600;
`endif
        errs = 0;
        do_reset();
        for (int c = 0; c < n_cyc; c++) begin
            step({8'($urandom), 8'hBC}, {8'($urandom), 8'hBC}, 2'b01, 2'b01, 1'($urandom));
            if (scrdat0[7:0] === 8'h1C) subs.push_back(c);
            if ({scrdat0, scrdat1, scrisk0, scrisk1} !== {e_dat0, e_dat1, e_isk0, e_isk1}) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("[TB] FAIL bs_stream_model: got %0d mismatching cycles, want 0", errs);
        end
        n_tests++;
`ifdef DPORT_SCR_SR_EN
        if (subs.size() != 2 || subs[0] != 0 || subs[1] != 512) begin
            n_fail++;
            $display("[TB] FAIL bs_substitution: got %0d substitutions (first %0d), want 2 at 0 and 512",
                     subs.size(), (subs.size() > 0) ? subs[0] : -1);
        end
`else
        if (subs.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL bs_substitution: got %0d substitutions, want 0", subs.size());
        end
`endif
    endtask

    task automatic test_two_bs();
        logic [15:0] want;
`ifdef DPORT_SCR_SR_EN
        want = 16'hBC1C;
`else
        want = 16'hBCBC;
`endif
        step(16'hBCBC, 16'hBCBC, 2'b11, 2'b11, 1'b1);
        n_tests++;
        if (scrdat0 !== want || scrdat1 !== want || scrisk0 !== 2'b11 || scrisk1 !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL two_bs: got %h %h isk %b %b, want %h %h isk 11 11", scrdat0, scrdat1, scrisk0, scrisk1, want, want);
        end
        step(16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
        n_tests++;
        if (scrdat0 !== e_dat0 || scrdat1 !== e_dat1) begin
            n_fail++;
            $display("[TB] FAIL two_bs_after: got %h %h, want %h %h", scrdat0, scrdat1, e_dat0, e_dat1);
        end
    endtask

    task automatic test_random();
        logic [15:0] d0, d1;
        logic [1:0]  k0, k1;
        for (int c = 0; c < 300; c++) begin
            d0 = 16'($urandom);
            d1 = 16'($urandom);
            k0 = 2'b00;
            k1 = 2'b00;
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 5) == 0) begin
                    k0[s] = 1'b1;
                    case ($urandom_range(0, 2))
                        0:       d0[8*s +: 8] = 8'hBC;
                        1:       d0[8*s +: 8] = 8'h1C;
                        default: d0[8*s +: 8] = 8'h7C;
                    endcase
                end
                if ($urandom_range(0, 7) == 0) k1[s] = 1'b1;
            end
            step(d0, d1, k0, k1, 1'($urandom));
            n_tests++;
            if ({scrdat0, scrdat1, scrisk0, scrisk1} !== {e_dat0, e_dat1, e_isk0, e_isk1}) begin
                n_fail++;
                $display("[TB] FAIL random_c%0d: got %h %h %b %b, want %h %h %b %b", c,
                         scrdat0, scrdat1, scrisk0, scrisk1, e_dat0, e_dat1, e_isk0, e_isk1);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] want;
`ifdef DPORT_SCR_SR_EN
        want = 16'hFF1C;
`else
        want = 16'h17BC;
`endif
        for (int c = 0; c < 5; c++) step(16'($urandom) | 16'h0101, 16'($urandom), 2'b00, 2'b00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({scrdat0, scrdat1, scrisk0, scrisk1} !== 36'h0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h %h %b %b, want all zero", scrdat0, scrdat1, scrisk0, scrisk1);
        end
        @(posedge dpclk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step({8'h00, 8'hBC}, {8'h00, 8'hBC}, 2'b01, 2'b01, 1'b1);
        n_tests++;
        if (scrdat0 !== want || scrdat1 !== want || scrisk0 !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL reset_first_bs: got %h %h isk %b, want %h %h isk 01", scrdat0, scrdat1, scrisk0, want, want);
        end
    endtask

    initial begin
        build_keystream();
        model_reset();
        test_reset();
        test_keystream();
        test_scren_off();
        test_sr_in_byte0();
        test_lane1_k();
        test_bs_period();
        test_two_bs();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
